// File: rtl/text_menu_pkg.sv
//------------------------------------------------------------------------------
// Module   : text_menu_pkg
// Brief    : Scan-code constants, item encodings, state enums and the item
//            stepping helper for the text menu controller.
//            Optional macro: MENU_WRAP_EN (item wrap-around at the ends).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package text_menu_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_F1    = 8'h05;
   localparam logic [7:0] SC_ESC   = 8'h76;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   localparam logic [2:0] ITEM_NONE  = 3'd0;
   localparam logic [2:0] ITEM_OPEN  = 3'd1;
   localparam logic [2:0] ITEM_SAVE  = 3'd2;
   localparam logic [2:0] ITEM_EXIT  = 3'd3;
   localparam logic [2:0] ITEM_CAPS  = 3'd4;
   localparam logic [2:0] ITEM_COLOR = 3'd5;
   localparam logic [2:0] ITEM_SIZE  = 3'd6;

   typedef enum logic [0:0] {
      MENU_CLOSED = 1'b0,
      MENU_OPEN   = 1'b1
   } menu_state_t;

   typedef enum logic [1:0] {
      DEC_WAIT    = 2'd0,
      DEC_EXT     = 2'd1,
      DEC_BRK     = 2'd2,
      DEC_EXT_BRK = 2'd3
   } dec_state_t;

   // Moves the highlight one step; the ends either wrap or saturate.
   function automatic logic [2:0] item_step(input logic [2:0] cur,
                                            input logic       up,
                                            input logic [2:0] last);
      logic [2:0] nxt;
      nxt = cur;
`ifdef MENU_WRAP_EN
      if (up)
         nxt = (cur >= last) ? ITEM_OPEN : cur + 3'd1;
      else
         nxt = (cur <= ITEM_OPEN) ? last : cur - 3'd1;
`else
      if (up)
         nxt = (cur >= last) ? cur : cur + 3'd1;
      else
         nxt = (cur <= ITEM_OPEN) ? cur : cur - 3'd1;
`endif
      return nxt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_make_decoder.sv
//------------------------------------------------------------------------------
// Module   : ps2_make_decoder
// Brief    : Strips E0/F0 prefixes from PS/2 bytes and emits registered make
//            events; break sequences are swallowed.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_make_decoder
   import text_menu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_done_tick,
   input  logic [7:0] scan_code,
   output logic       make_tick,
   output logic [7:0] make_code,
   output logic       make_ext
);

   dec_state_t r_state;
   dec_state_t w_next_state;
   logic       w_emit;
   logic       w_ext;
   logic       r_make_tick;
   logic [7:0] r_make_code;
   logic       r_make_ext;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= DEC_WAIT;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_emit       = 1'b0;
      w_ext        = 1'b0;
      if (rx_done_tick) begin
         case (r_state)
            DEC_WAIT: begin
               if (scan_code == SC_EXT)
                  w_next_state = DEC_EXT;
               else if (scan_code == SC_BRK)
                  w_next_state = DEC_BRK;
               else
                  w_emit = 1'b1;
            end
            DEC_EXT: begin
               // A repeated E0 keeps us waiting for the real extended byte.
               if (scan_code == SC_BRK) begin
                  w_next_state = DEC_EXT_BRK;
               end else if (scan_code != SC_EXT) begin
                  w_emit       = 1'b1;
                  w_ext        = 1'b1;
                  w_next_state = DEC_WAIT;
               end
            end
            DEC_BRK:     w_next_state = DEC_WAIT;
            DEC_EXT_BRK: w_next_state = DEC_WAIT;
            default:     w_next_state = DEC_WAIT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_make_tick <= 1'b0;
         r_make_code <= 8'h00;
         r_make_ext  <= 1'b0;
      end else begin
         r_make_tick <= w_emit;
         if (w_emit) begin
            r_make_code <= scan_code;
            r_make_ext  <= w_ext;
         end
      end
   end

   assign make_tick = r_make_tick;
   assign make_code = r_make_code;
   assign make_ext  = r_make_ext;

endmodule

`default_nettype wire

// File: rtl/text_menu_ctrl.sv
//------------------------------------------------------------------------------
// Module   : text_menu_ctrl
// Brief    : Keyboard navigation of the top menu bar with Enter command strobe
//            and inactivity auto-close. Optional macro: MENU_WRAP_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module text_menu_ctrl
   import text_menu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 250_000_000,
   parameter int TO_W           = 28,
   parameter int NUM_ITEMS      = 6
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_done_tick,
   input  logic [7:0] scan_code,
   output logic [2:0] item_selector,
   output logic       menu_active,
   output logic       cmd_tick,
   output logic [2:0] cmd_item
);

   localparam logic [TO_W-1:0] c_to_last   = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]      c_last_item = 3'(NUM_ITEMS);

   logic       w_make_tick;
   logic [7:0] w_make_code;
   logic       w_make_ext;

   ps2_make_decoder u_decoder (
      .clk          (clk),
      .reset        (reset),
      .rx_done_tick (rx_done_tick),
      .scan_code    (scan_code),
      .make_tick    (w_make_tick),
      .make_code    (w_make_code),
      .make_ext     (w_make_ext)
   );

   logic w_key_f1;
   logic w_key_esc;
   logic w_key_enter;
   logic w_key_left;
   logic w_key_right;

   assign w_key_f1    = w_make_tick && !w_make_ext && (w_make_code == SC_F1);
   assign w_key_esc   = w_make_tick && !w_make_ext && (w_make_code == SC_ESC);
   assign w_key_enter = w_make_tick && !w_make_ext && (w_make_code == SC_ENTER);
   assign w_key_left  = w_make_tick &&  w_make_ext && (w_make_code == SC_LEFT);
   assign w_key_right = w_make_tick &&  w_make_ext && (w_make_code == SC_RIGHT);

   menu_state_t     r_state;
   menu_state_t     w_next_state;
   logic [2:0]      r_item;
   logic [2:0]      w_next_item;
   logic            r_cmd_tick;
   logic            w_next_cmd_tick;
   logic [2:0]      r_cmd_item;
   logic [2:0]      w_next_cmd_item;
   logic [TO_W-1:0] r_to_cnt;
   logic [TO_W-1:0] w_next_to_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= MENU_CLOSED;
         r_item     <= ITEM_NONE;
         r_cmd_tick <= 1'b0;
         r_cmd_item <= ITEM_NONE;
         r_to_cnt   <= '0;
      end else begin
         r_state    <= w_next_state;
         r_item     <= w_next_item;
         r_cmd_tick <= w_next_cmd_tick;
         r_cmd_item <= w_next_cmd_item;
         r_to_cnt   <= w_next_to_cnt;
      end
   end

   always_comb begin
      w_next_state    = r_state;
      w_next_item     = r_item;
      w_next_cmd_tick = 1'b0;
      w_next_cmd_item = r_cmd_item;
      w_next_to_cnt   = '0;
      case (r_state)
         MENU_CLOSED: begin
            if (w_key_f1) begin
               w_next_state = MENU_OPEN;
               w_next_item  = ITEM_OPEN;
            end
         end
         MENU_OPEN: begin
            // A key arriving on the expiry cycle takes priority over timeout.
            if (w_make_tick) begin
               if (w_key_right) begin
                  w_next_item = item_step(r_item, 1'b1, c_last_item);
               end else if (w_key_left) begin
                  w_next_item = item_step(r_item, 1'b0, c_last_item);
               end else if (w_key_enter) begin
                  w_next_cmd_tick = 1'b1;
                  w_next_cmd_item = r_item;
                  w_next_state    = MENU_CLOSED;
                  w_next_item     = ITEM_NONE;
               end else if (w_key_esc) begin
                  w_next_state = MENU_CLOSED;
                  w_next_item  = ITEM_NONE;
               end
            end else if (r_to_cnt == c_to_last) begin
               w_next_state = MENU_CLOSED;
               w_next_item  = ITEM_NONE;
            end else begin
               w_next_to_cnt = r_to_cnt + 1'b1;
            end
         end
         default: begin
            w_next_state = MENU_CLOSED;
            w_next_item  = ITEM_NONE;
         end
      endcase
   end

   assign item_selector = r_item;
   assign menu_active   = (r_state == MENU_OPEN);
   assign cmd_tick      = r_cmd_tick;
   assign cmd_item      = r_cmd_item;

endmodule

`default_nettype wire

// File: tb/tb_text_menu_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_text_menu_ctrl
// Brief    : Self-checking bench for text_menu_ctrl with a 100-cycle timeout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_text_menu_ctrl;

   localparam logic [7:0] K_EXT   = 8'hE0;
   localparam logic [7:0] K_BRK   = 8'hF0;
   localparam logic [7:0] K_F1    = 8'h05;
   localparam logic [7:0] K_ESC   = 8'h76;
   localparam logic [7:0] K_ENTER = 8'h5A;
   localparam logic [7:0] K_LEFT  = 8'h6B;
   localparam logic [7:0] K_RIGHT = 8'h74;
   localparam logic [7:0] K_A     = 8'h1C;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_done_tick = 1'b0;
   logic [7:0] scan_code = 8'h00;
   logic [2:0] item_selector;
   logic       menu_active;
   logic       cmd_tick;
   logic [2:0] cmd_item;

   int checks = 0;
   int errors = 0;

   // Expected {menu_active, item_selector} for each visible output change.
   logic [3:0] exp_q[$];
   logic [2:0] exp_cmd_q[$];

   text_menu_ctrl #(
      .TIMEOUT_CYCLES (100),
      .TO_W           (7),
      .NUM_ITEMS      (6)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_done_tick  (rx_done_tick),
      .scan_code     (scan_code),
      .item_selector (item_selector),
      .menu_active   (menu_active),
      .cmd_tick      (cmd_tick),
      .cmd_item      (cmd_item)
   );

   always #5 clk = ~clk;

   logic [3:0] prev_out = 4'h0;
   logic       prev_cmd = 1'b0;

   always @(negedge clk) begin
      logic [3:0] e;
      logic [2:0] ec;
      if (!reset) begin
         prev_out = {menu_active, item_selector};
         prev_cmd = 1'b0;
      end else begin
         if ({menu_active, item_selector} !== prev_out) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL state_sb: unexpected change to active=%0b item=%0d", menu_active, item_selector);
            end else begin
               e = exp_q.pop_front();
               if ({menu_active, item_selector} !== e) begin
                  errors++;
                  $display("FAIL state_sb: got active=%0b item=%0d, expected active=%0b item=%0d",
                           menu_active, item_selector, e[3], e[2:0]);
               end
            end
         end
         if (prev_cmd) begin
            checks++;
            if (cmd_tick !== 1'b0) begin
               errors++;
               $display("FAIL cmd_width: cmd_tick=%b in second cycle, expected 0", cmd_tick);
            end
         end
         if (cmd_tick === 1'b1) begin
            checks++;
            if (exp_cmd_q.size() == 0) begin
               errors++;
               $display("FAIL cmd_sb: unexpected cmd_tick with cmd_item=%0d", cmd_item);
            end else begin
               ec = exp_cmd_q.pop_front();
               if (cmd_item !== ec) begin
                  errors++;
                  $display("FAIL cmd_sb: got cmd_item=%0d, expected %0d", cmd_item, ec);
               end
            end
         end
         prev_out = {menu_active, item_selector};
         prev_cmd = cmd_tick;
      end
   end

   task automatic drive_byte(input logic [7:0] b);
      @(negedge clk);
      rx_done_tick = 1'b1;
      scan_code    = b;
   endtask

   task automatic drop_tick();
      @(negedge clk);
      rx_done_tick = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      drive_byte(b);
      drop_tick();
   endtask

   task automatic send_ext(input logic [7:0] b);
      send_byte(K_EXT);
      send_byte(b);
   endtask

   task automatic expect_state(input logic act, input logic [2:0] item);
      exp_q.push_back({act, item});
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({item_selector, menu_active, cmd_tick, cmd_item} !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: got item=%0d active=%b cmd_tick=%b cmd_item=%0d, expected all 0",
                  item_selector, menu_active, cmd_tick, cmd_item);
      end
      @(negedge clk);
      #2 reset = 1'b1;
   endtask

   task automatic test_closed_ignore();
      send_ext(K_RIGHT);
      send_byte(K_ENTER);
      send_byte(K_ESC);
      @(negedge clk);
      checks++;
      if ({menu_active, item_selector} !== 4'h0) begin
         errors++;
         $display("FAIL closed_ignore: got active=%b item=%0d, expected 0/0", menu_active, item_selector);
      end
   endtask

   task automatic test_open();
      expect_state(1'b1, 3'd1);
      send_byte(K_F1);
      checks++;
      if (menu_active !== 1'b0) begin
         errors++;
         $display("FAIL open_latency: active=%b one clk after tick, expected 0", menu_active);
      end
      @(negedge clk);
      checks++;
      if ({menu_active, item_selector} !== 4'b1_001) begin
         errors++;
         $display("FAIL open: got active=%b item=%0d, expected 1/1", menu_active, item_selector);
      end
      send_byte(K_F1);
      @(negedge clk);
      checks++;
      if (item_selector !== 3'd1) begin
         errors++;
         $display("FAIL f1_while_open: got item=%0d, expected 1", item_selector);
      end
   endtask

   task automatic test_navigate();
      for (int i = 2; i <= 4; i++) begin
         expect_state(1'b1, 3'(i));
         send_ext(K_RIGHT);
         @(negedge clk);
         checks++;
         if (item_selector !== 3'(i)) begin
            errors++;
            $display("FAIL nav_right: got item=%0d, expected %0d", item_selector, i);
         end
      end
      send_byte(K_EXT);
      send_byte(K_BRK);
      send_byte(K_RIGHT);
      send_byte(K_BRK);
      send_byte(K_ENTER);
      send_byte(K_A);
      repeat (2) @(negedge clk);
      checks++;
      if ({menu_active, item_selector} !== 4'b1_100) begin
         errors++;
         $display("FAIL break_codes: got active=%b item=%0d, expected 1/4", menu_active, item_selector);
      end
   endtask

   task automatic test_boundary();
      logic [2:0] e;
      expect_state(1'b1, 3'd5);
      send_ext(K_RIGHT);
      expect_state(1'b1, 3'd6);
      send_ext(K_RIGHT);
      @(negedge clk);
`ifdef MENU_WRAP_EN
      e = 3'd1;
      expect_state(1'b1, 3'd1);
`else
      e = 3'd6;
`endif
      send_ext(K_RIGHT);
      @(negedge clk);
      checks++;
      if (item_selector !== e) begin
         errors++;
         $display("FAIL right_at_6: got item=%0d, expected %0d", item_selector, e);
      end
`ifndef MENU_WRAP_EN
      for (int i = 5; i >= 1; i--) begin
         expect_state(1'b1, 3'(i));
         send_ext(K_LEFT);
      end
      @(negedge clk);
      e = 3'd1;
`else
      e = 3'd6;
      expect_state(1'b1, 3'd6);
`endif
      send_ext(K_LEFT);
      @(negedge clk);
      checks++;
      if (item_selector !== e) begin
         errors++;
         $display("FAIL left_at_1: got item=%0d, expected %0d", item_selector, e);
      end
      expect_state(1'b0, 3'd0);
      send_byte(K_ESC);
      @(negedge clk);
   endtask

   task automatic test_enter();
      expect_state(1'b1, 3'd1);
      send_byte(K_F1);
      expect_state(1'b1, 3'd2);
      send_ext(K_RIGHT);
      @(negedge clk);
      exp_cmd_q.push_back(3'd2);
      expect_state(1'b0, 3'd0);
      send_byte(K_ENTER);
      checks++;
      if (cmd_tick !== 1'b0) begin
         errors++;
         $display("FAIL enter_latency: cmd_tick=%b one clk after tick, expected 0", cmd_tick);
      end
      @(negedge clk);
      checks++;
      if ({cmd_tick, cmd_item, menu_active, item_selector} !== 8'b1_010_0_000) begin
         errors++;
         $display("FAIL enter_cmd: got cmd_tick=%b cmd_item=%0d active=%b item=%0d, expected 1/2/0/0",
                  cmd_tick, cmd_item, menu_active, item_selector);
      end
      @(negedge clk);
      checks++;
      if ({cmd_tick, cmd_item} !== 4'b0_010) begin
         errors++;
         $display("FAIL enter_hold: got cmd_tick=%b cmd_item=%0d, expected 0/2", cmd_tick, cmd_item);
      end
   endtask

   task automatic test_esc();
      expect_state(1'b1, 3'd1);
      send_byte(K_F1);
      expect_state(1'b1, 3'd2);
      send_ext(K_RIGHT);
      expect_state(1'b1, 3'd3);
      send_ext(K_RIGHT);
      expect_state(1'b0, 3'd0);
      send_byte(K_ESC);
      @(negedge clk);
      checks++;
      if ({cmd_tick, cmd_item, menu_active, item_selector} !== 8'b0_010_0_000) begin
         errors++;
         $display("FAIL esc_close: got cmd_tick=%b cmd_item=%0d active=%b item=%0d, expected 0/2/0/0",
                  cmd_tick, cmd_item, menu_active, item_selector);
      end
   endtask

   task automatic test_back_to_back();
      expect_state(1'b1, 3'd1);
      send_byte(K_F1);
      @(negedge clk);
      expect_state(1'b1, 3'd2);
      expect_state(1'b1, 3'd3);
      expect_state(1'b1, 3'd2);
      drive_byte(K_EXT);
      drive_byte(K_RIGHT);
      drive_byte(K_EXT);
      drive_byte(K_RIGHT);
      drive_byte(K_EXT);
      drive_byte(K_LEFT);
      drop_tick();
      repeat (2) @(negedge clk);
      checks++;
      if (item_selector !== 3'd2) begin
         errors++;
         $display("FAIL back_to_back: got item=%0d, expected 2", item_selector);
      end
      expect_state(1'b0, 3'd0);
      send_byte(K_ESC);
      @(negedge clk);
   endtask

   task automatic test_timeout();
      expect_state(1'b1, 3'd1);
      send_byte(K_F1);
      @(negedge clk);
      repeat (99) @(negedge clk);
      checks++;
      if (menu_active !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early: active=%b at 99 idle cycles, expected 1", menu_active);
      end
      expect_state(1'b0, 3'd0);
      @(negedge clk);
      checks++;
      if ({menu_active, item_selector} !== 4'h0) begin
         errors++;
         $display("FAIL timeout_close: got active=%b item=%0d, expected 0/0", menu_active, item_selector);
      end
   endtask

   task automatic test_timeout_coincide();
      expect_state(1'b1, 3'd1);
      send_byte(K_F1);
      repeat (98) @(negedge clk);
      send_byte(K_A);
      @(negedge clk);
      checks++;
      if ({menu_active, item_selector} !== 4'b1_001) begin
         errors++;
         $display("FAIL key_at_expiry: got active=%b item=%0d, expected 1/1", menu_active, item_selector);
      end
      repeat (99) @(negedge clk);
      checks++;
      if (menu_active !== 1'b1) begin
         errors++;
         $display("FAIL timeout_restart_early: active=%b, expected 1", menu_active);
      end
      expect_state(1'b0, 3'd0);
      @(negedge clk);
      checks++;
      if (menu_active !== 1'b0) begin
         errors++;
         $display("FAIL timeout_restart_close: active=%b, expected 0", menu_active);
      end
   endtask

   task automatic test_reset_midseq();
      expect_state(1'b1, 3'd1);
      send_byte(K_F1);
      @(negedge clk);
      send_byte(K_EXT);
      #2 reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({item_selector, menu_active, cmd_tick, cmd_item} !== 8'h00) begin
         errors++;
         $display("FAIL midseq_reset_outputs: got item=%0d active=%b cmd_tick=%b cmd_item=%0d, expected all 0",
                  item_selector, menu_active, cmd_tick, cmd_item);
      end
      @(negedge clk);
      #2 reset = 1'b1;
      send_byte(K_RIGHT);
      @(negedge clk);
      checks++;
      if ({menu_active, item_selector} !== 4'h0) begin
         errors++;
         $display("FAIL midseq_74: got active=%b item=%0d, expected 0/0", menu_active, item_selector);
      end
      send_byte(K_EXT);
      #2 reset = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      expect_state(1'b1, 3'd1);
      send_byte(K_F1);
      @(negedge clk);
      checks++;
      if ({menu_active, item_selector} !== 4'b1_001) begin
         errors++;
         $display("FAIL midseq_f1: got active=%b item=%0d, expected 1/1", menu_active, item_selector);
      end
      send_byte(K_RIGHT);
      @(negedge clk);
      checks++;
      if (item_selector !== 3'd1) begin
         errors++;
         $display("FAIL midseq_plain_74: got item=%0d, expected 1", item_selector);
      end
      expect_state(1'b0, 3'd0);
      send_byte(K_ESC);
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_closed_ignore();
      test_open();
      test_navigate();
      test_boundary();
      test_enter();
      test_esc();
      test_back_to_back();
      test_timeout();
      test_timeout_coincide();
      test_reset_midseq();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL state_sb_drain: %0d expected changes never seen, expected 0", exp_q.size());
      end
      checks++;
      if (exp_cmd_q.size() != 0) begin
         errors++;
         $display("FAIL cmd_sb_drain: %0d expected commands never seen, expected 0", exp_cmd_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/text_menu_ctrl.md
Name: text_menu_ctrl

Overview:
Keyboard-driven navigation controller for the top menu bar: Open, Save, Exit, Caps, Color, Size. It consumes scan-code bytes from the PS/2 receiver and tracks menu open/closed state and the highlighted item. It drives the 3-bit item_selector that the menu graphics stage renders; 0 means none and 1..6 select an item. On Enter it emits a one-cycle command strobe to the editor core.

Parameters:
TIMEOUT_CYCLES, 250_000_000, inactivity cycles (5 s at 50 MHz) after which an open menu auto-closes.
TO_W, 28, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.
NUM_ITEMS, 6, number of menu items; legal item codes are 1..NUM_ITEMS.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
rx_done_tick  in  1  one-cycle strobe; scan_code is valid when this is high
scan_code  in  8  PS/2 byte from the receiver
item_selector  out  3  highlighted item: 0 = none/closed, 1..6 = item
menu_active  out  1  1 while the menu is open
cmd_tick  out  1  one-cycle strobe when an item is executed
cmd_item  out  3  item executed; valid when cmd_tick=1, held until the next command

Behaviour:
- Reset (reset=0, asynchronous): item_selector=0, menu_active=0, cmd_tick=0, cmd_item=0, timeout counter=0, decoder in WAIT.
- Scan decoder FSM, advanced only on rx_done_tick:
  - WAIT: on E0 go to EXT; on F0 go to BRK; on any other byte emit make(code, ext=0).
  - EXT: on F0 go to EXT_BRK; on any other byte emit make(code, ext=1) and return to WAIT.
  - BRK: on any byte, discard and return to WAIT.
  - EXT_BRK: on any byte, discard and return to WAIT.
  - Break codes never produce actions. A stray E0 while in EXT stays in EXT.
- Decoded keys:
  - F1 = 05 (ext=0)
  - Esc = 76 (ext=0)
  - Enter = 5A (ext=0)
  - Left = 6B (ext=1)
  - Right = 74 (ext=1)
- Make events are registered one cycle after the final byte's rx_done_tick. Actions take effect on item_selector/menu_active in the following cycle. Total latency is 2 clk from rx_done_tick of the final byte.
- Menu FSM:
  - CLOSED:
    - F1 -> OPEN with item_selector=1.
    - All other keys are ignored; item_selector stays 0.
  - OPEN:
    - Right: item_selector+1. Left: item_selector-1. Boundary handling is defined under Optional Feature.
    - Enter: cmd_tick=1 for exactly one cycle, cmd_item=item_selector, then -> CLOSED with item_selector=0.
    - Esc: -> CLOSED with item_selector=0 and no command.
    - F1 while OPEN: no effect.
    - Any other make code resets the timeout counter and does nothing else.
- Timeout:
  - The counter runs only in OPEN and clears to 0 on every make event and on entering OPEN.
  - When it reaches TIMEOUT_CYCLES-1, the next cycle goes -> CLOSED, item_selector=0, with no cmd_tick.
  - If a make event arrives in the same cycle as expiry, the key wins: it is processed and the counter clears.
- menu_active = (state==OPEN). item_selector is never outside 0..NUM_ITEMS.
- rx_done_tick is asserted at most once per byte. Back-to-back ticks on consecutive cycles must be handled without loss.

Optional Feature:
MENU_WRAP_EN
- Defined: Right on item 6 wraps to 1; Left on item 1 wraps to 6.
- Undefined: Right on item 6 and Left on item 1 saturate (no change, no error). The timeout counter still clears.

Decomposition:
- Package text_menu_pkg holds:
  - scan-code constants: SC_EXT=E0, SC_BRK=F0, SC_F1, SC_ESC, SC_ENTER, SC_LEFT, SC_RIGHT
  - item encodings: ITEM_NONE=0, ITEM_OPEN=1 .. ITEM_SIZE=6
  - the menu state enum
- One sub-module, ps2_make_decoder, contains the E0/F0 prefix FSM. Outputs: make_tick, make_code[7:0], make_ext. text_menu_ctrl instantiates it and implements the menu FSM and timeout.

Test Plan:
- Reset then F1 (05) -> 2 clk after the tick: menu_active=1, item_selector=1.
- Open, then send E0 74 three times -> item_selector=4. Send E0 F0 74 -> item_selector unchanged at 4.
- At item 6, send Right (E0 74) -> 1 with MENU_WRAP_EN, 6 without. At item 1, send Left (E0 6B) -> 6 with MENU_WRAP_EN, 1 without.
- At item 2, send Enter (5A) -> cmd_tick high exactly 1 cycle, cmd_item=2, then item_selector=0 and menu_active=0. Esc (76) at item 3 -> closes with no cmd_tick.
- With TIMEOUT_CYCLES=100: open and idle -> closes after 100 cycles. A key at cycle 99 (coincident with expiry) -> menu stays open and the counter restarts.
- Drive reset=0 mid-sequence after E0 has been received, then release and send 74 -> treated as non-extended 74 with no action (menu closed); all outputs 0 during reset.
